iot_event_encoder: RTL

//   Source side of the change/on_off event interface that drives the active IoT devices monitor.

---
 rtl/iot_mon_pkg.sv | 27 ++
 rtl/iot_rr_arbiter.sv | 30 +++
 rtl/iot_event_encoder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/iot_mon_pkg.sv
// Shared types and helpers for the IoT activity event encoder.
package iot_mon_pkg;

  localparam int unsigned N_DEV_DEF = 8;
  localparam int unsigned CNT_W_DEF = 8;

  // Upper bound on device count; the event id field is sized for it so one
  // struct type serves every legal N_DEV.
  localparam int unsigned N_DEV_MAX = 64;
  localparam int unsigned ID_W_MAX  = 6;

  typedef struct packed {
    logic                on_off;
    logic [ID_W_MAX-1:0] id;
  } iot_evt_t;

  // Number of set bits in a (zero-extended) device vector.
  function automatic int unsigned popcount(input logic [N_DEV_MAX-1:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < N_DEV_MAX; i++) begin
      c = c + {31'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/iot_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly
// after ptr, searching upward with wrap-around.
module iot_rr_arbiter #(
  parameter int unsigned N    = 8,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  input  logic            en,
  output logic            gnt_vld,
  output logic [IdxW-1:0] gnt_idx
);

  logic [IdxW-1:0] idx;

  // Scan N positions starting one past the pointer; first hit wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IdxW'((32'(ptr) + k) % N);
      if (en && !gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/iot_event_encoder.sv
// Turns per-device activity edges into one-cycle change/on_off events,
// emitted one per cycle in round-robin order.
// Optional feature: define INPUT_SYNC_EN to put a two-flop synchronizer on
// every dev_active bit (adds two cycles of latency).
module iot_event_encoder
  import iot_mon_pkg::*;
#(
  parameter int unsigned N_DEV = N_DEV_DEF,
  parameter int unsigned ID_W  = $clog2(N_DEV),
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] dev_active,
  input  logic             hold,
  output logic             change,
  output logic             on_off,
  output logic [ID_W-1:0]  dev_id,
  output logic [CNT_W-1:0] pending_cnt
);

  logic [N_DEV-1:0] act;
  logic [N_DEV-1:0] edg;
  logic [N_DEV-1:0] prev_q;
  logic [N_DEV-1:0] pend_q, pend_d;
  logic [N_DEV-1:0] dir_q, dir_d;
  logic [N_DEV-1:0] gnt_oh;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             change_q, change_d;
  iot_evt_t         evt_q, evt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt_vld;
  logic [ID_W-1:0]  gnt_idx;

`ifdef INPUT_SYNC_EN
  logic [N_DEV-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer ahead of edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= dev_active;
      sync2_q <= sync1_q;
    end
  end

  assign act = sync2_q;
`else
  assign act = dev_active;
`endif

  assign edg = act ^ prev_q;

  iot_rr_arbiter #(
    .N    (N_DEV),
    .IdxW (ID_W)
  ) u_arb (
    .req     (pend_q),
    .ptr     (rr_ptr_q),
    .en      (~hold),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // Per-device pending/direction update. An edge on a device that is pending
  // but not granted cancels the event (on followed by off nets to nothing);
  // an edge on the granted device re-arms it with the new level.
  always_comb begin
    gnt_oh = '0;
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
    pend_d = pend_q;
    dir_d  = dir_q;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      if (edg[i]) begin
        if (pend_q[i] && !gnt_oh[i]) begin
          pend_d[i] = 1'b0;
        end else begin
          pend_d[i] = 1'b1;
          dir_d[i]  = act[i];
        end
      end else if (gnt_oh[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  // Emission, pointer and counter next-state.
  always_comb begin
    change_d     = gnt_vld;
    evt_d.on_off = gnt_vld ? dir_q[gnt_idx] : 1'b0;
    evt_d.id     = gnt_vld ? ID_W_MAX'(gnt_idx) : '0;
    rr_ptr_d     = gnt_vld ? gnt_idx : rr_ptr_q;
    cnt_d        = CNT_W'(popcount(N_DEV_MAX'(pend_d)));
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q   <= '0;
      pend_q   <= '0;
      dir_q    <= '0;
      rr_ptr_q <= ID_W'(N_DEV - 1);
      change_q <= 1'b0;
      evt_q    <= '0;
      cnt_q    <= '0;
    end else begin
      prev_q   <= act;
      pend_q   <= pend_d;
      dir_q    <= dir_d;
      rr_ptr_q <= rr_ptr_d;
      change_q <= change_d;
      evt_q    <= evt_d;
      cnt_q    <= cnt_d;
    end
  end

  assign change      = change_q;
  assign on_off      = evt_q.on_off;
  assign dev_id      = evt_q.id[ID_W-1:0];
  assign pending_cnt = cnt_q;

  // Id bits above ID_W are always zero for this configuration.
  logic unused_id;
  assign unused_id = ^evt_q.id;

endmodule
